dbus_bridge_core: RTL
=====================

# dbus_bridge_core

Parametrised byte bridge between the UART FIFOs and the DBUS link engine, with one buffered channel per direction. UP runs UART RX to DBUS; DOWN runs DBUS to UART TX. Each channel adds a 2^c_DEPTHPOW2 FIFO, configurable status synchronisation, a sink-acknowledge watchdog and a loopback mode that routes UART RX straight back to UART TX. It sits between `uart_rx_3x_fifo`/`uart_tx_fifo` and `dbus` in the top level.

## Interface
- c_WIDTH, 8: data width of all byte paths.
- c_DEPTHPOW2, 2: log2 of each channel FIFO depth (4 entries).
- c_SYNC, 1: register stages on each incoming avail/busy status, minimum 1.
- c_TIMEOUT, 4095: cycles a sink may take to raise busy after enable; 0 disables the watchdog. Counter width is $clog2(c_TIMEOUT+1).

Ports:
- i_clock  in  1  single clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_loopback  in  1  1 = UART RX feeds UART TX and DBUS is idle.
- i_urx_avail  in  1  UART RX byte available.
- i_urx_data  in  c_WIDTH  UART RX byte.
- o_urx_read  out  1  4-phase read to UART RX.
- o_dbus_data  out  c_WIDTH  byte to DBUS.
- o_dbus_enable  out  1  send request to DBUS.
- i_dbus_busy  in  1  DBUS transmitting.
- i_dbus_avail  in  1  DBUS received byte available.
- i_dbus_data  in  c_WIDTH  DBUS received byte.
- o_dbus_read  out  1  4-phase read to DBUS.
- o_utx_data  out  c_WIDTH  byte to UART TX.
- o_utx_enable  out  1  send request to UART TX.
- i_utx_busy  in  1  UART TX busy.
- o_up_count  out  c_DEPTHPOW2+1  UP FIFO occupancy.
- o_down_count  out  c_DEPTHPOW2+1  DOWN FIFO occupancy.
- o_timeout  out  1  one-cycle pulse when the watchdog fires.
- o_timeouts  out  8  saturating watchdog event count.

## Operation
- All avail/busy inputs pass through c_SYNC flops. The FSMs use only the synchronised copies (avail_s, busy_s).
- **Source FSM** (one per channel; states S_IDLE, S_WAIT):
  - S_IDLE: if avail_s and the FIFO is not full, push the input data, drive read=1 and go to S_WAIT.
  - S_WAIT: when avail_s=0, drive read=0 and return to S_IDLE.
  - When the FIFO is full, read stays 0 and the byte stays in the upstream block.
- **Sink FSM** (one per channel; states K_IDLE, K_ACK, K_DONE):
  - K_IDLE: if the FIFO is non-empty and busy_s=0, pop the head into the data register, drive enable=1, clear the timer and go to K_ACK.
  - K_ACK: when busy_s=1, drive enable=0 and go to K_DONE. Otherwise, if c_TIMEOUT≠0 and the timer reaches c_TIMEOUT, drive enable=0, pulse o_timeout, increment o_timeouts (holds at 255) and go to K_DONE. The byte is dropped, not retried.
  - K_DONE: when busy_s=0, go to K_IDLE.
  - The data register holds its value from pop until the next pop.
- **Mode**: mode_r samples i_loopback only in cycles where both sink FSMs are in K_IDLE.
  - mode_r=0: UP sink drives the DBUS ports; DOWN sink drives the UART TX ports.
  - mode_r=1: UP sink drives the UART TX ports. o_dbus_enable=0 and o_dbus_read=0, so the DOWN source is held in S_IDLE. The DOWN FIFO keeps its contents and the DOWN sink is stalled.
- FIFO: circular, with pointers of c_DEPTHPOW2 bits and a count of c_DEPTHPOW2+1 bits. A push and pop in the same cycle leave the count unchanged. Pushes never occur when full; pops never occur when empty.
- A sink must hold busy for at least c_SYNC+1 cycles. Shorter pulses may be missed and end in a timeout.

## Timing
- Reset (async assert, sync deassert in effect): every output is 0, the FIFOs are empty, mode_r=0, FSMs are in S_IDLE/K_IDLE, and the timer and o_timeouts are 0.
- Asserting reset mid-handshake drops read/enable at once. Any byte in flight is lost.
- avail rising at edge N: read=1 after edge N+c_SYNC+1, and the FIFO count increments on that same edge.
- Empty FIFO and idle sink: a byte pushed at edge M gives enable=1 with valid data after edge M+1. The count decrements on that same edge.
- busy rising at edge B: enable=0 after edge B+c_SYNC+1.
- Watchdog: enable stays high for exactly c_TIMEOUT+1 cycles, then falls in the same edge that raises o_timeout.
- Throughput per channel is at most one byte per 2·(c_SYNC+1)+2 cycles on each side.

## Test plan
- **Basic UP transfer**: with c_SYNC=1, UART RX presents 0xA5 and DBUS responds with a 10-cycle busy. Required: o_urx_read rises 2 cycles after avail, o_dbus_data=0xA5 with enable for 1 handshake, o_up_count returns to 0.
- **Backpressure**: hold i_dbus_busy=1 and offer 6 bytes 0x01..0x06. Required: 4 bytes accepted, o_up_count=4, read stays low for the 5th. On releasing busy, 0x01..0x06 arrive in order.
- **Watchdog**: with c_TIMEOUT=16, DBUS never raises busy. Required: enable high for 17 cycles, o_timeout pulses once, o_timeouts=1, the next byte is served. A variant with 300 unanswered bytes shows o_timeouts saturating at 255.
- **Loopback**: set i_loopback mid-transfer. Required: the switch happens only after the current sink handshake completes. RX bytes 0x10, 0x20 then appear on o_utx_data, and o_dbus_enable and o_dbus_read stay 0.
- **Full duplex**: run simultaneous streams of 0x00..0x0F UP and 0xF0..0xFF DOWN. Required: no loss or reordering, and both counts end at 0.
- **Async reset**: assert i_reset_n=0 mid-S_WAIT with the FIFO holding 3 bytes. Required: all outputs go 0 immediately and both counts read 0 after release.

Source files
------------

// File: rtl/dbus_bridge_core.sv
// rtl/dbus_bridge_core.sv - UART/DBUS byte bridge with buffered UP and DOWN channels
// Each channel: status synchroniser, 4-phase source FSM, circular FIFO, sink FSM with watchdog.

module dbus_bridge_sync #(
  parameter int c_SYNC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [c_SYNC-1:0] sr;

  if (c_SYNC == 1) begin : g_one
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr <= '0;
      else        sr <= d;
    end
  end else begin : g_many
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr <= '0;
      else        sr <= {sr[c_SYNC-2:0], d};
    end
  end

  assign q = sr[c_SYNC-1];
endmodule

module dbus_bridge_fifo #(
  parameter int c_WIDTH     = 8,
  parameter int c_DEPTHPOW2 = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [c_WIDTH-1:0]     wdata,
  input  logic                   pop,
  output logic [c_WIDTH-1:0]     rdata,
  output logic [c_DEPTHPOW2:0]   count,
  output logic                   full,
  output logic                   empty
);
  localparam int DEPTH = 1 << c_DEPTHPOW2;

  logic [c_WIDTH-1:0]     mem [DEPTH];
  logic [c_DEPTHPOW2-1:0] wr_ptr;
  logic [c_DEPTHPOW2-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (c_DEPTHPOW2+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

module dbus_bridge_source (
  input  logic clk,
  input  logic rst_n,
  input  logic avail,
  input  logic run,
  input  logic full,
  output logic push,
  output logic read
);
  typedef enum logic {S_IDLE, S_WAIT} src_state_t;
  src_state_t state;

  // A full FIFO leaves the byte parked upstream with read low.
  assign push = (state == S_IDLE) && avail && run && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      read  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (push) begin
          read  <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: if (!avail) begin
          read  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

module dbus_bridge_sink #(
  parameter int c_WIDTH   = 8,
  parameter int c_TIMEOUT = 4095
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               empty,
  input  logic [c_WIDTH-1:0] rdata,
  input  logic               busy,
  output logic               pop,
  output logic               fire,
  output logic               idle,
  output logic               enable,
  output logic [c_WIDTH-1:0] data
);
  localparam int TW = (c_TIMEOUT > 0) ? $clog2(c_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {K_IDLE, K_ACK, K_DONE} snk_state_t;
  snk_state_t    state;
  logic [TW-1:0] timer;

  assign idle = (state == K_IDLE);
  assign pop  = idle && run && !empty && !busy;
  assign fire = (c_TIMEOUT != 0) && (state == K_ACK) && !busy && (timer == TW'(c_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= K_IDLE;
      timer  <= '0;
      enable <= 1'b0;
      data   <= '0;
    end else begin
      case (state)
        K_IDLE: if (pop) begin
          data   <= rdata;
          enable <= 1'b1;
          timer  <= '0;
          state  <= K_ACK;
        end
        K_ACK: if (busy || fire) begin
          // An unanswered byte is dropped; the sink moves on.
          enable <= 1'b0;
          state  <= K_DONE;
        end else if (c_TIMEOUT != 0) begin
          timer <= timer + TW'(1);
        end
        K_DONE: if (!busy) state <= K_IDLE;
        default: state <= K_IDLE;
      endcase
    end
  end
endmodule

module dbus_bridge_core #(
  parameter int c_WIDTH     = 8,
  parameter int c_DEPTHPOW2 = 2,
  parameter int c_SYNC      = 1,
  parameter int c_TIMEOUT   = 4095
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_loopback,
  input  logic                 i_urx_avail,
  input  logic [c_WIDTH-1:0]   i_urx_data,
  output logic                 o_urx_read,
  output logic [c_WIDTH-1:0]   o_dbus_data,
  output logic                 o_dbus_enable,
  input  logic                 i_dbus_busy,
  input  logic                 i_dbus_avail,
  input  logic [c_WIDTH-1:0]   i_dbus_data,
  output logic                 o_dbus_read,
  output logic [c_WIDTH-1:0]   o_utx_data,
  output logic                 o_utx_enable,
  input  logic                 i_utx_busy,
  output logic [c_DEPTHPOW2:0] o_up_count,
  output logic [c_DEPTHPOW2:0] o_down_count,
  output logic                 o_timeout,
  output logic [7:0]           o_timeouts
);
  logic urx_avail_s, dbus_avail_s, dbus_busy_s, utx_busy_s;
  logic mode_r, switch_mode;
  logic up_push, up_pop, up_full, up_empty, up_fire, up_idle, up_enable;
  logic dn_push, dn_pop, dn_full, dn_empty, dn_fire, dn_idle, dn_enable;
  logic [c_WIDTH-1:0] up_rdata, up_data, dn_rdata, dn_data;
  logic [8:0] timeout_sum;

  dbus_bridge_sync #(.c_SYNC(c_SYNC)) u_sync_urx  (.clk(i_clock), .rst_n(i_reset_n), .d(i_urx_avail),  .q(urx_avail_s));
  dbus_bridge_sync #(.c_SYNC(c_SYNC)) u_sync_davl (.clk(i_clock), .rst_n(i_reset_n), .d(i_dbus_avail), .q(dbus_avail_s));
  dbus_bridge_sync #(.c_SYNC(c_SYNC)) u_sync_dbsy (.clk(i_clock), .rst_n(i_reset_n), .d(i_dbus_busy),  .q(dbus_busy_s));
  dbus_bridge_sync #(.c_SYNC(c_SYNC)) u_sync_ubsy (.clk(i_clock), .rst_n(i_reset_n), .d(i_utx_busy),   .q(utx_busy_s));

  // Mode changes take a cycle of their own with both sinks held, so no pop races the reroute.
  assign switch_mode = up_idle && dn_idle && (i_loopback != mode_r);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)       mode_r <= 1'b0;
    else if (switch_mode) mode_r <= i_loopback;
  end

  dbus_bridge_source u_up_src (
    .clk(i_clock), .rst_n(i_reset_n), .avail(urx_avail_s), .run(1'b1),
    .full(up_full), .push(up_push), .read(o_urx_read)
  );

  dbus_bridge_fifo #(.c_WIDTH(c_WIDTH), .c_DEPTHPOW2(c_DEPTHPOW2)) u_up_fifo (
    .clk(i_clock), .rst_n(i_reset_n), .push(up_push), .wdata(i_urx_data), .pop(up_pop),
    .rdata(up_rdata), .count(o_up_count), .full(up_full), .empty(up_empty)
  );

  dbus_bridge_sink #(.c_WIDTH(c_WIDTH), .c_TIMEOUT(c_TIMEOUT)) u_up_snk (
    .clk(i_clock), .rst_n(i_reset_n), .run(!switch_mode), .empty(up_empty), .rdata(up_rdata),
    .busy(mode_r ? utx_busy_s : dbus_busy_s), .pop(up_pop), .fire(up_fire), .idle(up_idle),
    .enable(up_enable), .data(up_data)
  );

  dbus_bridge_source u_dn_src (
    .clk(i_clock), .rst_n(i_reset_n), .avail(dbus_avail_s), .run(!mode_r),
    .full(dn_full), .push(dn_push), .read(o_dbus_read)
  );

  dbus_bridge_fifo #(.c_WIDTH(c_WIDTH), .c_DEPTHPOW2(c_DEPTHPOW2)) u_dn_fifo (
    .clk(i_clock), .rst_n(i_reset_n), .push(dn_push), .wdata(i_dbus_data), .pop(dn_pop),
    .rdata(dn_rdata), .count(o_down_count), .full(dn_full), .empty(dn_empty)
  );

  dbus_bridge_sink #(.c_WIDTH(c_WIDTH), .c_TIMEOUT(c_TIMEOUT)) u_dn_snk (
    .clk(i_clock), .rst_n(i_reset_n), .run(!switch_mode && !mode_r), .empty(dn_empty),
    .rdata(dn_rdata), .busy(utx_busy_s), .pop(dn_pop), .fire(dn_fire), .idle(dn_idle),
    .enable(dn_enable), .data(dn_data)
  );

  assign o_dbus_data   = up_data;
  assign o_dbus_enable = up_enable && !mode_r;
  assign o_utx_data    = mode_r ? up_data : dn_data;
  assign o_utx_enable  = mode_r ? up_enable : dn_enable;

  assign timeout_sum = {1'b0, o_timeouts} + 9'(up_fire) + 9'(dn_fire);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_timeout  <= 1'b0;
      o_timeouts <= '0;
    end else begin
      o_timeout  <= up_fire || dn_fire;
      o_timeouts <= (timeout_sum > 9'd255) ? 8'hFF : timeout_sum[7:0];
    end
  end
endmodule
